// File: rtl/exc_source_if.sv
// Exception request handshake bundle between the cause collector and the exception unit.
interface exc_source_if #(
   parameter int NIRQ = 4
);
   logic            invalid_op;
   logic [NIRQ-1:0] irq;
   logic [NIRQ-1:0] irq_mask;
   logic            ExcAck;
   logic            ERet;
   logic            Exc;
   logic [3:0]      EStatus;
   logic            busy;
   logic [NIRQ-1:0] pending;
   logic            timeout_err;

   modport master (
      input  invalid_op, irq, irq_mask, ExcAck, ERet,
      output Exc, EStatus, busy, pending, timeout_err
   );

   modport slave (
      output invalid_op, irq, irq_mask, ExcAck, ERet,
      input  Exc, EStatus, busy, pending, timeout_err
   );
endinterface

// File: rtl/exc_source_ctrl.sv
// Collects exception causes, arbitrates by fixed priority and runs the Exc/ExcAck/ERet handshake.
//
// state   | meaning
// IDLE    | arbitrating; raises a request when a cause is eligible
// REQ     | Exc held with stable EStatus, waiting for ExcAck or timeout
// SERVICE | handler running; new requests blocked until ERet
module exc_source_ctrl #(
   parameter int NIRQ        = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input logic          clk,
   input logic          reset,
   exc_source_if.master bus
);
   localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t          state_q, state_d;
   logic            exc_q, exc_d;
   logic [3:0]      estatus_q, estatus_d;
   logic            busy_q, busy_d;
   logic            terr_q, terr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NIRQ-1:0] pending_q, pending_d;
   logic [NIRQ-1:0] irq_q;
   logic [NIRQ-1:0] eligible;
   logic [NIRQ-1:0] clr;
   logic            win_found;
   logic [3:0]      win_code;

   assign eligible = pending_q & ~bus.irq_mask;

   // Lowest-numbered eligible line wins; scanning downward leaves the lowest hit last.
   always_comb begin
      win_found = 1'b0;
      win_code  = 4'd0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_found = 1'b1;
            win_code  = 4'(i + 2);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      exc_d     = exc_q;
      estatus_d = estatus_q;
      busy_d    = busy_q;
      terr_d    = terr_q;
      cnt_d     = cnt_q;
      clr       = '0;
      case (state_q)
         IDLE: begin
            if (bus.invalid_op) begin
               estatus_d = 4'd1;
               exc_d     = 1'b1;
               cnt_d     = '0;
               state_d   = REQ;
            end else if (win_found) begin
               estatus_d = win_code;
               exc_d     = 1'b1;
               cnt_d     = '0;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (bus.ExcAck) begin
               exc_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = SERVICE;
               for (int i = 0; i < NIRQ; i++) begin
                  if (estatus_q == 4'(i + 2)) clr[i] = 1'b1;
               end
            end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
               exc_d   = 1'b0;
               terr_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SERVICE: begin
            if (bus.ERet) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A fresh edge in the clearing cycle must survive, so set is applied after clear.
      pending_d = (pending_q & ~clr) | (bus.irq & ~irq_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         exc_q     <= 1'b0;
         estatus_q <= 4'd0;
         busy_q    <= 1'b0;
         terr_q    <= 1'b0;
         cnt_q     <= '0;
         pending_q <= '0;
         irq_q     <= '0;
      end else begin
         state_q   <= state_d;
         exc_q     <= exc_d;
         estatus_q <= estatus_d;
         busy_q    <= busy_d;
         terr_q    <= terr_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         irq_q     <= bus.irq;
      end
   end

   assign bus.Exc         = exc_q;
   assign bus.EStatus     = estatus_q;
   assign bus.busy        = busy_q;
   assign bus.pending     = pending_q;
   assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_exc_source_ctrl.sv
// Directed and randomized checks of exc_source_ctrl against a behavioural request model.
module tb_exc_source_ctrl;
   localparam int NIRQ = 4;
   localparam int TMO  = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   exc_source_if #(.NIRQ(NIRQ)) bus ();
   exc_source_ctrl #(.NIRQ(NIRQ), .ACK_TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Behavioural model: phase 0 waiting, 1 requesting, 2 handler running.
   int              m_phase;
   int              m_req_cycles;
   logic            m_exc, m_busy, m_terr;
   logic [3:0]      m_code;
   logic [NIRQ-1:0] m_pend, m_prev_irq;

   task automatic model_reset();
      m_phase = 0; m_req_cycles = 0; m_exc = 0; m_busy = 0; m_terr = 0;
      m_code = 0; m_pend = 0; m_prev_irq = 0;
   endtask

   task automatic model_step();
      logic [NIRQ-1:0] elig, low, taken;
      taken = '0;
      case (m_phase)
         0: begin
            elig = m_pend & ~bus.irq_mask;
            if (bus.invalid_op) begin
               m_code = 1; m_exc = 1; m_phase = 1; m_req_cycles = 0;
            end else if (elig != 0) begin
               low = elig & (~elig + 1'b1);
               m_code = 4'($clog2(low) + 2); m_exc = 1; m_phase = 1; m_req_cycles = 0;
            end
         end
         1: begin
            m_req_cycles++;
            if (bus.ExcAck) begin
               m_exc = 0; m_busy = 1; m_phase = 2;
               if (m_code >= 2) taken = NIRQ'(1) << (m_code - 2);
            end else if (m_req_cycles == TMO) begin
               m_exc = 0; m_terr = 1; m_phase = 0;
            end
         end
         default: begin
            if (bus.ERet) begin m_busy = 0; m_phase = 0; end
         end
      endcase
      m_pend = (m_pend & ~taken) | (bus.irq & ~m_prev_irq);
      m_prev_irq = bus.irq;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset(); else model_step();
      #1;
   endtask

   task automatic test_reset();
      total++; if (bus.Exc !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b exp=0", bus.Exc); end
      total++; if (bus.EStatus !== 4'd0) begin bad++; $display("FAIL reset_estatus got=%h exp=0", bus.EStatus); end
      total++; if (bus.pending !== 4'd0) begin bad++; $display("FAIL reset_pending got=%b exp=0000", bus.pending); end
      total++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin bad++;
         $display("FAIL reset_busy_terr got=%b%b exp=00", bus.busy, bus.timeout_err); end
   endtask

   task automatic test_reset_mid_req();
      bus.irq = 4'b0010; tick(); tick();
      total++; if (bus.Exc !== 1'b1 || bus.EStatus !== 4'd3) begin bad++;
         $display("FAIL midreq_setup got=%b/%h exp=1/3", bus.Exc, bus.EStatus); end
      #2 reset = 1'b1; bus.irq = '0;
      #1;
      total++; if ({bus.Exc, bus.EStatus, bus.pending, bus.busy, bus.timeout_err} !== 11'd0) begin bad++;
         $display("FAIL midreq_async got=%b/%h/%b/%b/%b exp=all0", bus.Exc, bus.EStatus, bus.pending, bus.busy, bus.timeout_err); end
      model_reset();
      #2 reset = 1'b0;
      tick();
   endtask

   task automatic test_irq1_flow();
      bus.irq = 4'b0010; tick();
      total++; if (bus.Exc !== 1'b0 || bus.pending !== 4'b0010) begin bad++;
         $display("FAIL irq1_edge got=%b/%b exp=0/0010", bus.Exc, bus.pending); end
      tick();
      total++; if (bus.Exc !== 1'b1 || bus.EStatus !== 4'd3) begin bad++;
         $display("FAIL irq1_req got=%b/%h exp=1/3", bus.Exc, bus.EStatus); end
      tick(); tick();
      total++; if (bus.Exc !== 1'b1 || bus.EStatus !== 4'd3) begin bad++;
         $display("FAIL irq1_hold got=%b/%h exp=1/3", bus.Exc, bus.EStatus); end
      bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
      total++; if (bus.Exc !== 1'b0 || bus.busy !== 1'b1 || bus.pending[1] !== 1'b0) begin bad++;
         $display("FAIL irq1_ack got=%b/%b/%b exp=0/1/0", bus.Exc, bus.busy, bus.pending[1]); end
      bus.irq = '0;
      for (int i = 0; i < 4; i++) tick();
      bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
      total++; if (bus.busy !== 1'b0 || bus.Exc !== 1'b0) begin bad++;
         $display("FAIL irq1_eret got=%b/%b exp=0/0", bus.busy, bus.Exc); end
   endtask

   task automatic test_priority();
      bus.irq = 4'b0001; tick();
      bus.invalid_op = 1'b1; tick(); bus.invalid_op = 1'b0;
      total++; if (bus.Exc !== 1'b1 || bus.EStatus !== 4'd1) begin bad++;
         $display("FAIL prio_invop got=%b/%h exp=1/1", bus.Exc, bus.EStatus); end
      bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
      bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
      total++; if (bus.pending[0] !== 1'b1) begin bad++;
         $display("FAIL prio_pend0 got=%b exp=1", bus.pending[0]); end
      tick();
      total++; if (bus.Exc !== 1'b1 || bus.EStatus !== 4'd2) begin bad++;
         $display("FAIL prio_second got=%b/%h exp=1/2", bus.Exc, bus.EStatus); end
      bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
      bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
      bus.irq = '0; tick();
   endtask

   task automatic test_mask_service();
      bus.invalid_op = 1'b1; tick(); bus.invalid_op = 1'b0;
      bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
      bus.irq_mask = 4'b0100; bus.irq = 4'b0100; tick();
      total++; if (bus.pending[2] !== 1'b1 || bus.Exc !== 1'b0 || bus.busy !== 1'b1) begin bad++;
         $display("FAIL mask_service got=%b/%b/%b exp=1/0/1", bus.pending[2], bus.Exc, bus.busy); end
      bus.ERet = 1'b1; tick(); bus.ERet = 1'b0; tick();
      total++; if (bus.pending[2] !== 1'b1 || bus.Exc !== 1'b0) begin bad++;
         $display("FAIL mask_idle got=%b/%b exp=1/0", bus.pending[2], bus.Exc); end
      bus.irq_mask = '0; tick();
      total++; if (bus.Exc !== 1'b1 || bus.EStatus !== 4'd4) begin bad++;
         $display("FAIL mask_unmask got=%b/%h exp=1/4", bus.Exc, bus.EStatus); end
      bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
      bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
      bus.irq = '0; tick();
   endtask

   task automatic test_timeout();
      bus.irq = 4'b0001; tick(); tick();
      total++; if (bus.Exc !== 1'b1 || bus.EStatus !== 4'd2) begin bad++;
         $display("FAIL tmo_req got=%b/%h exp=1/2", bus.Exc, bus.EStatus); end
      tick(); tick(); tick();
      total++; if (bus.Exc !== 1'b1 || bus.timeout_err !== 1'b0) begin bad++;
         $display("FAIL tmo_before got=%b/%b exp=1/0", bus.Exc, bus.timeout_err); end
      tick();
      total++; if (bus.Exc !== 1'b0 || bus.timeout_err !== 1'b1 || bus.pending[0] !== 1'b1) begin bad++;
         $display("FAIL tmo_expire got=%b/%b/%b exp=0/1/1", bus.Exc, bus.timeout_err, bus.pending[0]); end
      tick();
      total++; if (bus.Exc !== 1'b1 || bus.EStatus !== 4'd2) begin bad++;
         $display("FAIL tmo_rerise got=%b/%h exp=1/2", bus.Exc, bus.EStatus); end
      bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
      bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
      bus.irq = '0; tick();
   endtask

   task automatic test_back_to_back();
      bus.irq = 4'b0001; tick();
      bus.irq = 4'b0000; tick();
      total++; if (bus.Exc !== 1'b1 || bus.EStatus !== 4'd2) begin bad++;
         $display("FAIL b2b_req got=%b/%h exp=1/2", bus.Exc, bus.EStatus); end
      bus.irq = 4'b0001; bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
      total++; if (bus.pending[0] !== 1'b1 || bus.busy !== 1'b1) begin bad++;
         $display("FAIL b2b_setwins got=%b/%b exp=1/1", bus.pending[0], bus.busy); end
      bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
      total++; if (bus.Exc !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", bus.Exc); end
      tick();
      total++; if (bus.Exc !== 1'b1 || bus.EStatus !== 4'd2) begin bad++;
         $display("FAIL b2b_second got=%b/%h exp=1/2", bus.Exc, bus.EStatus); end
      bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
      bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
      bus.irq = '0; tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         for (int b = 0; b < NIRQ; b++) if ($urandom_range(0, 4) == 0) bus.irq[b] = ~bus.irq[b];
         if ($urandom_range(0, 9) == 0) bus.irq_mask = NIRQ'($urandom);
         bus.invalid_op = ($urandom_range(0, 9) == 0);
         bus.ExcAck     = ($urandom_range(0, 3) == 0);
         bus.ERet       = ($urandom_range(0, 3) == 0);
         tick();
         total++;
         if ({bus.Exc, bus.EStatus, bus.busy, bus.pending, bus.timeout_err} !==
             {m_exc, m_code, m_busy, m_pend, m_terr}) begin
            bad++;
            $display("FAIL random_cycle%0d got exc=%b st=%h busy=%b pend=%b terr=%b exp exc=%b st=%h busy=%b pend=%b terr=%b",
                     n, bus.Exc, bus.EStatus, bus.busy, bus.pending, bus.timeout_err,
                     m_exc, m_code, m_busy, m_pend, m_terr);
         end
      end
   endtask

   initial begin
      bus.invalid_op = 1'b0; bus.irq = '0; bus.irq_mask = '0; bus.ExcAck = 1'b0; bus.ERet = 1'b0;
      model_reset();
      #3;
      test_reset();
      #19 reset = 1'b0;
      tick();
      test_reset_mid_req();
      test_irq1_flow();
      test_priority();
      test_mask_service();
      test_timeout();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
